control_decode_stage: RTL and testbench

// - Registered ID-stage control generator: decodes opFunc/category into per-field control, holds it in a valid/ready output register.
// - Adds load-use hazard bubbles, flush, and a multi-cycle MUL/DIV issue sequencer that blocks issue while HI/LO is busy.
// - Sits between the ID-stage instruction register and the ID/EX pipeline register.

---
 rtl/control_decode_stage_if.sv | 44 ++++
 rtl/control_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_control_decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_decode_stage_if.sv
// control_decode_stage_if: instruction-in / control-out bundle for the ID-stage
// control generator. The master side supplies the decoded instruction, hazard
// inputs, flush and downstream ready; the slave side (the decode stage) returns
// the handshake and the registered control fields.
interface control_decode_stage_if #(
  parameter int OPFUNC_W   = 12,
  parameter int CAT_W      = 16,
  parameter int REG_ADDR_W = 5
);
  logic                  inValid;
  logic                  inReady;
  logic [OPFUNC_W-1:0]   opFunc;
  logic [CAT_W-1:0]      category;
  logic [REG_ADDR_W-1:0] rsAddr;
  logic [REG_ADDR_W-1:0] rtAddr;
  logic                  exLoad;
  logic [REG_ADDR_W-1:0] exWriteAddr;
  logic                  flush;
  logic                  outValid;
  logic                  outReady;
  logic                  memWriteEn;
  logic [1:0]            regWrAddrSrc;
  logic                  regWrDataSrc;
  logic                  reg1AddrSrc;
  logic [1:0]            pcAction;
  logic [1:0]            aluData2Src;
  logic [1:0]            shamtSrc;
  logic                  mdStart;
  logic                  mdBusy;

  modport master (
    output inValid, opFunc, category, rsAddr, rtAddr, exLoad, exWriteAddr,
           flush, outReady,
    input  inReady, outValid, memWriteEn, regWrAddrSrc, regWrDataSrc,
           reg1AddrSrc, pcAction, aluData2Src, shamtSrc, mdStart, mdBusy
  );

  modport slave (
    input  inValid, opFunc, category, rsAddr, rtAddr, exLoad, exWriteAddr,
           flush, outReady,
    output inReady, outValid, memWriteEn, regWrAddrSrc, regWrDataSrc,
           reg1AddrSrc, pcAction, aluData2Src, shamtSrc, mdStart, mdBusy
  );
endinterface

// File: rtl/control_decode_stage.sv
// control_decode_stage: registered ID-stage control generator. Decodes
// opFunc/category into per-field control held in a valid/ready output register,
// inserts load-use bubbles, honours flush, and sequences multi-cycle MUL/DIV
// issue so nothing else issues while HI/LO is busy.
// Optional feature macro: CONTROL_HAZARD_EN (load-use hazard detection; when
// undefined the hazard term is tied low and exLoad/exWriteAddr are ignored).
module control_decode_stage #(
  parameter int                  OPFUNC_W    = 12,
  parameter int                  CAT_W       = 16,
  parameter int                  REG_ADDR_W  = 5,
  parameter logic [OPFUNC_W-1:0] LUI_OPFUNC  = OPFUNC_W'('h00F),
  parameter int                  MUL_LATENCY = 4,
  parameter int                  DIV_LATENCY = 32
) (
  input logic                   clock,
  input logic                   resetN,
  control_decode_stage_if.slave bus
);

  // Category bit positions
  localparam int CAT_LOAD   = 0;
  localparam int CAT_STORE  = 1;
  localparam int CAT_BRANCH = 2;
  localparam int CAT_JUMP   = 3;
  localparam int CAT_RJUMP  = 4;
  localparam int CAT_RSHIFT = 5;
  localparam int CAT_LOGIC  = 6;
  localparam int CAT_MULDIV = 7;
  localparam int CAT_DIV    = 8;

  // Field encodings
  localparam logic [1:0] WA_NONE   = 2'd0;
  localparam logic [1:0] WA_RD     = 2'd1;
  localparam logic [1:0] WA_RT     = 2'd2;
  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] A2_REG    = 2'd0;
  localparam logic [1:0] A2_IMMS   = 2'd1;
  localparam logic [1:0] A2_IMMU   = 2'd2;
  localparam logic [1:0] SH_NONE   = 2'd0;
  localparam logic [1:0] SH_SHAMT  = 2'd1;
  localparam logic [1:0] SH_C16    = 2'd2;

  // Busy counter holds LATENCY-1 down to 0
  localparam int LAT_MAX = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mdStart_q;
  logic             mdBusy_q;

  logic       outValid_q;
  logic       memWriteEn_q,   memWriteEn_d;
  logic [1:0] regWrAddrSrc_q, regWrAddrSrc_d;
  logic       regWrDataSrc_q, regWrDataSrc_d;
  logic       reg1AddrSrc_q,  reg1AddrSrc_d;
  logic [1:0] pcAction_q,     pcAction_d;
  logic [1:0] aluData2Src_q,  aluData2Src_d;
  logic [1:0] shamtSrc_q,     shamtSrc_d;

  logic is_func;
  logic hazard;
  logic slot_free;
  logic in_ready;
  logic accept;
  logic start_md;
  logic unused_inputs;

  assign is_func = bus.opFunc[OPFUNC_W-1];

`ifdef CONTROL_HAZARD_EN
  // Rt is a source for R-type, stores (data) and branches (compare)
  logic rt_read;
  assign rt_read = is_func | bus.category[CAT_STORE] | bus.category[CAT_BRANCH];
  assign hazard  = bus.exLoad & (bus.exWriteAddr != '0) &
                   ((bus.exWriteAddr == bus.rsAddr) |
                    (rt_read & (bus.exWriteAddr == bus.rtAddr)));
  assign unused_inputs = ^bus.category;
`else
  assign hazard        = 1'b0;
  assign unused_inputs = ^{bus.category, bus.exLoad, bus.exWriteAddr};
`endif

  // The output slot can take new data when empty or being drained this cycle
  assign slot_free = ~outValid_q | bus.outReady;
  assign in_ready  = (state_q == ST_RUN) & ~hazard & ~bus.flush & slot_free;
  assign accept    = bus.inValid & in_ready;
  assign start_md  = accept & bus.category[CAT_MULDIV];

  // Combinational decode of the incoming instruction into control fields
  always_comb begin
    memWriteEn_d   = bus.category[CAT_STORE];
    regWrDataSrc_d = bus.category[CAT_LOAD];
    reg1AddrSrc_d  = bus.category[CAT_RSHIFT];

    if (is_func) begin
      if (bus.category[CAT_RJUMP] | bus.category[CAT_MULDIV]) regWrAddrSrc_d = WA_NONE;
      else                                                     regWrAddrSrc_d = WA_RD;
    end else begin
      if (bus.category[CAT_BRANCH] | bus.category[CAT_JUMP])  regWrAddrSrc_d = WA_NONE;
      else                                                     regWrAddrSrc_d = WA_RT;
    end

    if (bus.category[CAT_JUMP] | bus.category[CAT_RJUMP]) pcAction_d = PC_JUMP;
    else if (bus.category[CAT_BRANCH])                    pcAction_d = PC_BRANCH;
    else                                                  pcAction_d = PC_INC;

    if (is_func | bus.category[CAT_BRANCH]) aluData2Src_d = A2_REG;
    else if (bus.category[CAT_LOGIC])       aluData2Src_d = A2_IMMU;
    else                                    aluData2Src_d = A2_IMMS;

    if (bus.category[CAT_RSHIFT])         shamtSrc_d = SH_SHAMT;
    else if (bus.opFunc == LUI_OPFUNC)    shamtSrc_d = SH_C16;
    else                                  shamtSrc_d = SH_NONE;
  end

  // Output register: load on accept, bubble when drained without a new accept
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid_q     <= 1'b0;
      memWriteEn_q   <= 1'b0;
      regWrAddrSrc_q <= 2'd0;
      regWrDataSrc_q <= 1'b0;
      reg1AddrSrc_q  <= 1'b0;
      pcAction_q     <= 2'd0;
      aluData2Src_q  <= 2'd0;
      shamtSrc_q     <= 2'd0;
    end else if (bus.flush) begin
      outValid_q <= 1'b0;
    end else if (accept) begin
      outValid_q     <= 1'b1;
      memWriteEn_q   <= memWriteEn_d;
      regWrAddrSrc_q <= regWrAddrSrc_d;
      regWrDataSrc_q <= regWrDataSrc_d;
      reg1AddrSrc_q  <= reg1AddrSrc_d;
      pcAction_q     <= pcAction_d;
      aluData2Src_q  <= aluData2Src_d;
      shamtSrc_q     <= shamtSrc_d;
    end else if (slot_free) begin
      outValid_q <= 1'b0;
    end
  end

  // MUL/DIV issue sequencer: hold off issue for LATENCY cycles after a MulDiv accept
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mdStart_q <= 1'b0;
      mdBusy_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mdStart_q <= 1'b0;
      mdBusy_q  <= 1'b0;
    end else begin
      mdStart_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (start_md) begin
            state_q   <= ST_WAIT;
            cnt_q     <= bus.category[CAT_DIV] ? DIV_LOAD : MUL_LOAD;
            mdStart_q <= 1'b1;
            mdBusy_q  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= ST_RUN;
            mdBusy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.inReady      = in_ready;
  assign bus.outValid     = outValid_q;
  assign bus.memWriteEn   = memWriteEn_q;
  assign bus.regWrAddrSrc = regWrAddrSrc_q;
  assign bus.regWrDataSrc = regWrDataSrc_q;
  assign bus.reg1AddrSrc  = reg1AddrSrc_q;
  assign bus.pcAction     = pcAction_q;
  assign bus.aluData2Src  = aluData2Src_q;
  assign bus.shamtSrc     = shamtSrc_q;
  assign bus.mdStart      = mdStart_q;
  assign bus.mdBusy       = mdBusy_q;

endmodule

// File: tb/tb_control_decode_stage.sv
// tb_control_decode_stage: directed bench for control_decode_stage with a
// behavioural reference model and a per-cycle comparison process.
module tb_control_decode_stage;
  localparam int OW = 12;
  localparam int CW = 16;
  localparam int AW = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam logic [OW-1:0] LUI_OP = 12'h00F;
`ifdef CONTROL_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  // Instruction encodings (opFunc, category)
  localparam logic [OW-1:0] OP_ADD = 12'h820, OP_ORI = 12'h00D, OP_MUL = 12'h818;
  localparam logic [OW-1:0] OP_DIV = 12'h81A, OP_LW = 12'h023, OP_SW = 12'h02B;
  localparam logic [OW-1:0] OP_BEQ = 12'h004, OP_J = 12'h002, OP_JR = 12'h808;
  localparam logic [OW-1:0] OP_SLL = 12'h800;
  localparam logic [CW-1:0] C_NONE = 16'h0000, C_LOAD = 16'h0001, C_STORE = 16'h0002;
  localparam logic [CW-1:0] C_BR = 16'h0004, C_J = 16'h0008, C_RJ = 16'h0010;
  localparam logic [CW-1:0] C_SH = 16'h0020, C_LOG = 16'h0040, C_MUL = 16'h0080;
  localparam logic [CW-1:0] C_DIV = 16'h0180;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  control_decode_stage_if #(.OPFUNC_W(OW), .CAT_W(CW), .REG_ADDR_W(AW)) bus ();

  control_decode_stage #(
    .OPFUNC_W(OW), .CAT_W(CW), .REG_ADDR_W(AW), .LUI_OPFUNC(LUI_OP),
    .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       memWriteEn;
    logic [1:0] regWrAddrSrc;
    logic       regWrDataSrc;
    logic       reg1AddrSrc;
    logic [1:0] pcAction;
    logic [1:0] aluData2Src;
    logic [1:0] shamtSrc;
  } ctl_t;

  function automatic ctl_t spec_decode(input logic [OW-1:0] op, input logic [CW-1:0] cat);
    ctl_t c;
    bit   func;
    func           = op[OW-1];
    c.memWriteEn   = cat[1];
    c.regWrDataSrc = cat[0];
    c.reg1AddrSrc  = cat[5];
    c.regWrAddrSrc = func ? ((cat[4] || cat[7]) ? 2'd0 : 2'd1)
                          : ((cat[2] || cat[3]) ? 2'd0 : 2'd2);
    c.pcAction     = (cat[3] || cat[4]) ? 2'd2 : (cat[2] ? 2'd1 : 2'd0);
    c.aluData2Src  = (func || cat[2]) ? 2'd0 : (cat[6] ? 2'd2 : 2'd1);
    c.shamtSrc     = cat[5] ? 2'd1 : ((op == LUI_OP) ? 2'd2 : 2'd0);
    return c;
  endfunction

  bit   m_valid = 1'b0;
  bit   m_start = 1'b0;
  int   m_busy  = 0;     // cycles of HI/LO busy still to be seen
  ctl_t m_ctl   = '0;

  function automatic bit spec_hazard();
    bit rt_read;
    rt_read = bus.opFunc[OW-1] || bus.category[1] || bus.category[2];
    return HZ_EN && bus.exLoad && (bus.exWriteAddr != 0) &&
           ((bus.exWriteAddr == bus.rsAddr) || (rt_read && (bus.exWriteAddr == bus.rtAddr)));
  endfunction

  function automatic bit exp_ready();
    return (m_busy == 0) && !spec_hazard() && !bus.flush && (!m_valid || bus.outReady);
  endfunction

  always @(posedge clock or negedge resetN) begin
    bit acc;
    if (!resetN) begin
      m_valid = 1'b0; m_start = 1'b0; m_busy = 0; m_ctl = '0;
    end else begin
      acc = bus.inValid && exp_ready();
      if (bus.flush) begin
        m_valid = 1'b0; m_start = 1'b0; m_busy = 0;
      end else begin
        m_start = acc && bus.category[7];
        if (acc && bus.category[7]) m_busy = bus.category[8] ? DIV_LAT : MUL_LAT;
        else if (m_busy > 0)        m_busy = m_busy - 1;
        if (acc) begin
          m_valid = 1'b1;
          m_ctl   = spec_decode(bus.opFunc, bus.category);
        end else if (!m_valid || bus.outReady) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  function automatic ctl_t dut_ctl();
    return {bus.memWriteEn, bus.regWrAddrSrc, bus.regWrDataSrc, bus.reg1AddrSrc,
            bus.pcAction, bus.aluData2Src, bus.shamtSrc};
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (resetN) begin
      check("inReady",  32'(bus.inReady),  32'(exp_ready()));
      check("outValid", 32'(bus.outValid), 32'(m_valid));
      check("mdStart",  32'(bus.mdStart),  32'(m_start));
      check("mdBusy",   32'(bus.mdBusy),   32'(m_busy != 0));
      check("fields",   32'(dut_ctl()),    32'(m_ctl));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [OW-1:0] op, input logic [CW-1:0] cat,
                           input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    bus.inValid  = v;
    bus.opFunc   = op;
    bus.category = cat;
    bus.rsAddr   = rs;
    bus.rtAddr   = rt;
  endtask

  task automatic idle();
    set_instr(1'b0, OP_ADD, C_NONE, 5'd0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] tbl_op  [6];
    logic [CW-1:0] tbl_cat [6];
    logic [1:0]    tbl_pc  [6];
    logic [1:0]    tbl_wa  [6];
    ctl_t held;
    int n;

    tbl_op  = '{OP_J, OP_JR, OP_BEQ, OP_SLL, OP_LW, OP_SW};
    tbl_cat = '{C_J,  C_RJ,  C_BR,   C_SH,   C_LOAD, C_STORE};
    tbl_pc  = '{2'd2, 2'd2,  2'd1,   2'd0,   2'd0,   2'd0};
    tbl_wa  = '{2'd0, 2'd0,  2'd0,   2'd1,   2'd2,   2'd2};

    idle();
    bus.exLoad = 1'b0; bus.exWriteAddr = '0; bus.flush = 1'b0; bus.outReady = 1'b1;
    repeat (2) tick();
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_mdBusy",   32'(bus.mdBusy),   32'd0);
    check("rst_mdStart",  32'(bus.mdStart),  32'd0);
    check("rst_fields",   32'(dut_ctl()),    32'd0);
    resetN = 1'b1;
    tick();

    // ADD R-type
    set_instr(1'b1, OP_ADD, C_NONE, 5'd1, 5'd2);
    tick();
    idle();
    check("add_valid", 32'(bus.outValid),     32'd1);
    check("add_wa",    32'(bus.regWrAddrSrc), 32'd1);
    check("add_a2",    32'(bus.aluData2Src),  32'd0);
    check("add_pc",    32'(bus.pcAction),     32'd0);

    // ORI then LUI back-to-back
    set_instr(1'b1, OP_ORI, C_LOG, 5'd3, 5'd4);
    tick();
    check("ori_a2", 32'(bus.aluData2Src), 32'd2);
    set_instr(1'b1, LUI_OP, C_NONE, 5'd0, 5'd4);
    tick();
    idle();
    check("lui_valid", 32'(bus.outValid),    32'd1);
    check("lui_sh",    32'(bus.shamtSrc),    32'd2);
    check("lui_a2",    32'(bus.aluData2Src), 32'd1);
    tick();

    // Load-use hazard on rs
    set_instr(1'b1, OP_ADD, C_NONE, 5'd5, 5'd0);
    bus.exLoad = 1'b1; bus.exWriteAddr = 5'd5;
    #1 check("hz_rs_ready", 32'(bus.inReady), 32'(!HZ_EN));
    tick();
    check("hz_rs_valid", 32'(bus.outValid), 32'(!HZ_EN));
    // Store reads rt; ORI writes rt so it is not a source
    set_instr(1'b1, OP_SW, C_STORE, 5'd1, 5'd5);
    #1 check("hz_sw_ready", 32'(bus.inReady), 32'(!HZ_EN));
    set_instr(1'b1, OP_ORI, C_LOG, 5'd1, 5'd5);
    #1 check("hz_ori_ready", 32'(bus.inReady), 32'd1);
    bus.exWriteAddr = 5'd0;
    set_instr(1'b1, OP_ADD, C_NONE, 5'd0, 5'd0);
    #1 check("hz_r0_ready", 32'(bus.inReady), 32'd1);
    bus.exLoad = 1'b0;
    tick();
    idle();
    tick();

    // MUL issue and busy window, ADD waiting behind it
    set_instr(1'b1, OP_MUL, C_MUL, 5'd1, 5'd2);
    tick();
    set_instr(1'b1, OP_ADD, C_NONE, 5'd1, 5'd2);
    check("mul_start", 32'(bus.mdStart),      32'd1);
    check("mul_busy1", 32'(bus.mdBusy),       32'd1);
    check("mul_wa",    32'(bus.regWrAddrSrc), 32'd0);
    #1 check("mul_ready1", 32'(bus.inReady), 32'd0);
    for (int i = 2; i <= MUL_LAT; i++) begin
      tick();
      check("mul_busyN", 32'(bus.mdBusy), 32'd1);
    end
    tick();
    check("mul_busy_end", 32'(bus.mdBusy),  32'd0);
    check("mul_ready5",   32'(bus.inReady), 32'd1);
    tick();
    idle();
    check("mul_next_wa", 32'(bus.regWrAddrSrc), 32'd1);
    tick();

    // DIV busy length
    set_instr(1'b1, OP_DIV, C_DIV, 5'd1, 5'd2);
    tick();
    idle();
    n = 0;
    while (bus.mdBusy && n < 100) begin
      tick();
      n++;
    end
    check("div_busy_len", 32'(n), 32'd32);
    tick();

    // Flush during DIV wait
    set_instr(1'b1, OP_DIV, C_DIV, 5'd1, 5'd2);
    tick();
    idle();
    repeat (5) tick();
    bus.flush = 1'b1;
    #1 check("fl_ready_during", 32'(bus.inReady), 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("fl_busy",  32'(bus.mdBusy),   32'd0);
    check("fl_valid", 32'(bus.outValid), 32'd0);
    check("fl_ready", 32'(bus.inReady),  32'd1);
    tick();

    // Downstream stall holds the register
    set_instr(1'b1, OP_LW, C_LOAD, 5'd1, 5'd9);
    tick();
    bus.outReady = 1'b0;
    set_instr(1'b1, OP_SW, C_STORE, 5'd1, 5'd9);
    #1 check("st_ready", 32'(bus.inReady), 32'd0);
    held = dut_ctl();
    check("st_lw_ds", 32'(bus.regWrDataSrc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_valid", 32'(bus.outValid), 32'd1);
      check("st_hold",  32'(dut_ctl()),    32'(held));
    end
    bus.outReady = 1'b1;
    #1 check("st_release", 32'(bus.inReady), 32'd1);
    tick();
    idle();
    check("st_sw_we", 32'(bus.memWriteEn),   32'd1);
    check("st_sw_ds", 32'(bus.regWrDataSrc), 32'd0);

    // Control-flow and misc decode table, back to back
    for (int i = 0; i < 6; i++) begin
      set_instr(1'b1, tbl_op[i], tbl_cat[i], 5'd2, 5'd3);
      tick();
      check("tbl_pc", 32'(bus.pcAction),     32'(tbl_pc[i]));
      check("tbl_wa", 32'(bus.regWrAddrSrc), 32'(tbl_wa[i]));
    end
    idle();
    tick();

    // Varying outReady with a stream of instructions
    for (int i = 0; i < 24; i++) begin
      set_instr(1'(i % 3 != 2), tbl_op[i % 6], tbl_cat[i % 6], 5'(i), 5'(i + 1));
      bus.outReady = 1'(i % 4 != 1);
      tick();
    end
    idle();
    bus.outReady = 1'b1;
    tick();

    // Reset in the middle of a DIV wait
    set_instr(1'b1, OP_DIV, C_DIV, 5'd1, 5'd2);
    tick();
    idle();
    repeat (3) tick();
    resetN = 1'b0;
    #1;
    check("rst_mid_busy",  32'(bus.mdBusy),   32'd0);
    check("rst_mid_valid", 32'(bus.outValid), 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    check("rst_mid_ready", 32'(bus.inReady), 32'd1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
